// File: rtl/iterative_mdu.sv
// Iterative RV32M/RV64M multiply-divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, with a
// valid/ready handshake on both sides. Divide-by-zero and signed overflow
// bypass the iteration loop.
// Optional feature: define MDU_REUSE_EN to keep the last divide result in a
// tag so that a matching DIV/REM (or DIVU/REMU) pair skips the iteration loop.
module iterative_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] a_data_in,
  input  logic [XLEN-1:0] b_data_in,
  input  logic [2:0]      uop_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     b_mag_q;
  logic [XLEN-1:0]     result_q;
  logic [2:0]          uop_q;
  logic                neg_q;
  logic                valid_q;
  logic [CW-1:0]       count_q;

  // Operand decode at the acceptance edge: signedness, magnitudes, bypasses.
  logic            signed_a, signed_b, sa, sb, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf, special, reuse_hit;
  logic [2*XLEN-1:0] reuse_acc;

  assign signed_a    = (uop_in != 3'd3) && !(uop_in[2] && uop_in[0]);
  assign signed_b    = (uop_in != 3'd2) && (uop_in != 3'd3) && !(uop_in[2] && uop_in[0]);
  assign sa          = signed_a & a_data_in[XLEN-1];
  assign sb          = signed_b & b_data_in[XLEN-1];
  assign a_mag       = sa ? -a_data_in : a_data_in;
  assign b_mag       = sb ? -b_data_in : b_data_in;
  // Remainder takes the dividend's sign; products and quotients take sa^sb.
  assign neg_in      = (uop_in[2] && uop_in[1]) ? sa : (sa ^ sb);
  assign div_by_zero = uop_in[2] && (b_data_in == '0);
  assign div_ovf     = uop_in[2] && !uop_in[0] && (a_data_in == MIN_NEG) && (b_data_in == '1);
  assign special     = div_by_zero | div_ovf;

`ifdef MDU_REUSE_EN
  logic            tag_valid_q, tag_signed_q;
  logic [XLEN-1:0] tag_a_q, tag_b_q, tag_quo_q, tag_rem_q;
  logic [XLEN-1:0] a_raw_q, b_raw_q;

  assign reuse_hit = uop_in[2] && tag_valid_q && (a_data_in == tag_a_q) &&
                     (b_data_in == tag_b_q) && (tag_signed_q == !uop_in[0]);
  assign reuse_acc = {tag_rem_q, tag_quo_q};
`else
  assign reuse_hit = 1'b0;
  assign reuse_acc = '0;
`endif

  // One iteration step of each algorithm on the {hi, lo} accumulator.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_mag_q};
  assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Final sign correction and half selection.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_mag, div_res, fin_res;

  assign prod    = neg_q ? -acc_q : acc_q;
  assign mul_res = (uop_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign div_mag = uop_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_res = neg_q ? -div_mag : div_mag;
  assign fin_res = uop_q[2] ? div_res : mul_res;

  assign ready_out  = (state_q == IDLE);
  assign valid_out  = valid_q;
  assign result_out = result_q;

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; bypassed ops go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_in) state_d = (special || reuse_hit) ? DONE : BUSY;
      BUSY: if (count_q == LAST) state_d = DONE;
      DONE: if (valid_q && ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in BUSY, publish result on first DONE edge.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      acc_q    <= '0;
      b_mag_q  <= '0;
      uop_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (valid_in) begin
          uop_q   <= uop_in;
          b_mag_q <= b_mag;
          count_q <= '0;
          // Bypass results are preloaded as already-corrected accumulator values.
          if (div_by_zero) begin
            acc_q <= {a_data_in, {XLEN{1'b1}}};
            neg_q <= 1'b0;
          end else if (div_ovf) begin
            acc_q <= {{XLEN{1'b0}}, a_data_in};
            neg_q <= 1'b0;
          end else if (reuse_hit) begin
            acc_q <= reuse_acc;
            neg_q <= neg_in;
          end else begin
            acc_q <= {{XLEN{1'b0}}, a_mag};
            neg_q <= neg_in;
          end
        end
        BUSY: begin
          acc_q   <= uop_q[2] ? div_next : mul_next;
          count_q <= (count_q == LAST) ? '0 : count_q + CW'(1);
        end
        DONE: begin
          if (!valid_q) begin
            result_q <= fin_res;
            valid_q  <= 1'b1;
          end else if (ready_in) begin
            valid_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_REUSE_EN
  // Reuse tag: capture raw operands on accept, record each divide that finishes BUSY.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      tag_valid_q  <= 1'b0;
      tag_signed_q <= 1'b0;
      tag_a_q      <= '0;
      tag_b_q      <= '0;
      tag_quo_q    <= '0;
      tag_rem_q    <= '0;
      a_raw_q      <= '0;
      b_raw_q      <= '0;
    end else begin
      if (state_q == IDLE && valid_in) begin
        a_raw_q <= a_data_in;
        b_raw_q <= b_data_in;
      end
      if (state_q == BUSY && count_q == LAST && uop_q[2]) begin
        tag_valid_q  <= 1'b1;
        tag_signed_q <= !uop_q[0];
        tag_a_q      <= a_raw_q;
        tag_b_q      <= b_raw_q;
        tag_quo_q    <= div_next[XLEN-1:0];
        tag_rem_q    <= div_next[2*XLEN-1:XLEN];
      end
    end
  end
`endif

endmodule

// File: tb/tb_iterative_mdu.sv
// Directed testbench for iterative_mdu (XLEN=32) with hand-computed vectors.
module tb_iterative_mdu;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] a_data_in;
  logic [31:0] b_data_in;
  logic [2:0]  uop_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result_out;

  int tests = 0;
  int errs  = 0;

  iterative_mdu #(.XLEN(32)) dut (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .a_data_in  (a_data_in),
    .b_data_in  (b_data_in),
    .uop_in     (uop_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result_out (result_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, then count edges after the acceptance edge until valid_out.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clock_in);
    uop_in = op; a_data_in = a; b_data_in = b; valid_in = 1'b1;
    @(posedge clock_in); #1;
    valid_in  = 1'b0;
    a_data_in = 32'hA5A5_5A5A;
    b_data_in = 32'h0F0F_F0F0;
    uop_in    = ~op;
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clock_in); #1;
      lat++;
    end
    res = result_out;
  endtask

  task automatic release_result(input string tag);
    @(negedge clock_in);
    ready_in = 1'b1;
    @(posedge clock_in); #1;
    ready_in = 1'b0;
    check({tag, "_vout_clr"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, ready_out}, 32'd1);
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    run_op(op, a, b, res, lat);
    check(tag, res, exp);
    check({tag, "_lat"}, lat, exp_lat);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int vcount;

    reset_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    a_data_in = '0; b_data_in = '0; uop_in = '0;
    repeat (2) @(posedge clock_in);
    #1;
    reset_in = 1'b0;
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_result", result_out, 32'd0);

    op_check("mul",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    op_check("mul_lo",  3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 33);
    op_check("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    op_check("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    op_check("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    op_check("div",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    op_check("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    op_check("divu",    3'd5, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 33);
    op_check("div_ps",  3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    op_check("divu_z",  3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 1);
    op_check("remu_z",  3'd7, 32'd5,         32'd0,        32'd5,         1);
    op_check("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

    // Back-pressure: hold ready_in low in DONE while poking valid_in.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("bp_first", res, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_in);
      check("bp_result", result_out, 32'hFFFF_FFFD);
      check("bp_valid", {31'd0, valid_out}, 32'd1);
      check("bp_ready", {31'd0, ready_out}, 32'd0);
      uop_in = 3'd0; a_data_in = 32'd1; b_data_in = 32'd1; valid_in = 1'b1;
      @(posedge clock_in); #1;
      valid_in = 1'b0;
    end
    release_result("bp");
    check("bp_keep", result_out, 32'hFFFF_FFFD);
    vcount = 0;
    repeat (40) begin
      @(posedge clock_in); #1;
      if (valid_out) vcount++;
    end
    check("bp_no_ghost", vcount, 0);

    // Reset during BUSY after 10 iterations.
    @(negedge clock_in);
    uop_in = 3'd0; a_data_in = 32'h0000_FFFF; b_data_in = 32'h0000_FFFF; valid_in = 1'b1;
    @(posedge clock_in); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clock_in);
    @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    check("abort_ready", {31'd0, ready_out}, 32'd1);
    check("abort_valid", {31'd0, valid_out}, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(posedge clock_in); #1;
      if (valid_out) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    op_check("mul_after", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Divide result reuse.
    op_check("reuse_div", 3'd4, 32'd100, 32'd7, 32'd14, 33);
`ifdef MDU_REUSE_EN
    op_check("reuse_rem", 3'd6, 32'd100, 32'd7, 32'd2, 1);
`else
    op_check("reuse_rem", 3'd6, 32'd100, 32'd7, 32'd2, 33);
`endif
    op_check("remu",      3'd7, 32'd100, 32'd7, 32'd2, 33);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
